// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, RS(255,239) code dimensions and the syndrome FSM
// state type for the RS decoder front end.
package rs_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;  // low byte of x^8+x^4+x^3+x^2+1
  localparam int RS_K    = 239;
  localparam int RS_NPAR = 16;
  localparam int RS_N    = RS_K + RS_NPAR;

  typedef enum logic {IDLE, ACCUM} state_t;

  // alpha^e as a field element; evaluated at elaboration to set lane constants.
  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e % 255; k++) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? GF_POLY : 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(2^8) multiply by a fixed constant: sums the shifted-and-reduced
// copies of the input selected by the set bits of CONST.
module gf_const_mul
  import rs_pkg::*;
#(
  parameter logic [7:0] CONST = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] p
);

  logic [7:0] term;

  // NOTE: blocking '=' is deliberate in always_comb so each loop pass sees the
  // term updated by the previous pass; registered state always uses '<='.
  always_comb begin
    term = a;
    p    = '0;
    for (int b = 0; b < 8; b++) begin
      if (CONST[b]) p = p ^ term;
      term = {term[6:0], 1'b0} ^ (term[7] ? GF_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator: Horner accumulation of NPAR syndromes over a
// streamed frame. Define RS_ABORT_CNT_EN to build the saturating aborted-frame counter.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int N    = RS_N,
  parameter int NPAR = RS_NPAR,
  parameter int FCR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic                din_valid,
  input  logic                sof,
  output logic                syn_valid,
  output logic [8*NPAR-1:0]   syn,
  output logic                err_det,
  output logic                busy,
  output logic [7:0]          abort_cnt
);

  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic [7:0]          acc      [NPAR];
  logic [7:0]          acc_nxt  [NPAR];
  logic [7:0]          prod     [NPAR];
  logic [8*NPAR-1:0]   syn_nxt;
  logic                done;

  for (genvar i = 0; i < NPAR; i++) begin : g_lane
    gf_const_mul #(.CONST(alpha_pow(i + FCR))) u_mul (
      .a (acc[i]),
      .p (prod[i])
    );
    assign syn_nxt[8*i +: 8] = acc_nxt[i];
  end

  // NOTE: every signal written here gets its hold value first, so no path through
  // the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    for (int i = 0; i < NPAR; i++) acc_nxt[i] = acc[i];

    if (din_valid) begin
      if (sof) begin
        // A start of frame always restarts: fresh frame from IDLE, abort in ACCUM.
        state_nxt = ACCUM;
        cnt_nxt   = 8'd1;
        for (int i = 0; i < NPAR; i++) acc_nxt[i] = din;
      end else if (state == ACCUM) begin
        for (int i = 0; i < NPAR; i++) acc_nxt[i] = prod[i] ^ din;
        if (cnt == 8'(N - 1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    end
  end

  // NOTE: the accumulator array is reset explicitly so a frame cut short by reset
  // leaves no residue; it is a handful of registers, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < NPAR; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      for (int i = 0; i < NPAR; i++) acc[i] <= acc_nxt[i];
    end
  end

  // Syndromes and the error flag change only on a completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syn_valid <= 1'b0;
      syn       <= '0;
      err_det   <= 1'b0;
    end else begin
      syn_valid <= done;
      if (done) begin
        syn     <= syn_nxt;
        err_det <= |syn_nxt;
      end
    end
  end

  assign busy = (state == ACCUM);

`ifdef RS_ABORT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_cnt <= '0;
    end else if (state == ACCUM && din_valid && sof && abort_cnt != 8'hFF) begin
      abort_cnt <= abort_cnt + 8'd1;
    end
  end
`else
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: frames are scored against syndromes
// evaluated directly as r(alpha^i) with log/antilog field tables.
module tb_rs_syndrome_calc;
  import rs_pkg::*;

`ifdef RS_ABORT_CNT_EN
  localparam logic [7:0] EXP_ABORTS = 8'd1;
`else
  localparam logic [7:0] EXP_ABORTS = 8'd0;
`endif

  logic           clk;
  logic           rst;
  logic [7:0]     din;
  logic           din_valid;
  logic           sof;
  logic           syn_valid;
  logic [127:0]   syn;
  logic           err_det;
  logic           busy;
  logic [7:0]     abort_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]   gexp [255];
  int           glog [256];
  logic [7:0]   frm  [255];
  logic [7:0]   codeword [255];
  logic [127:0] exp_syn;

  rs_syndrome_calc dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sof       (sof),
    .syn_valid (syn_valid),
    .syn       (syn),
    .err_det   (err_det),
    .busy      (busy),
    .abort_cnt (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  task automatic init_tables();
    int x;
    x = 1;
    for (int k = 0; k < 255; k++) begin
      gexp[k] = 8'(x);
      glog[x] = k;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11D;
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // S_i = sum over degree d of r_d * alpha^(i*d); frm[k] holds degree 254-k.
  function automatic logic [127:0] model_syn();
    logic [127:0] s;
    logic [7:0]   acc;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      acc = 8'h00;
      for (int k = 0; k < 255; k++) acc = acc ^ gmul(frm[k], gexp[(i * (254 - k)) % 255]);
      s[8*i +: 8] = acc;
    end
    return s;
  endfunction

  // Systematic encoding: message 0x01..0xEF, parity = m(x)x^16 mod g(x).
  task automatic build_codeword();
    logic [7:0] g [17];
    logic [7:0] w [255];
    logic [7:0] c;
    for (int d = 0; d < 17; d++) g[d] = 8'h00;
    g[0] = 8'h01;
    for (int r = 0; r < 16; r++) begin
      for (int d = 16; d >= 1; d--) g[d] = g[d-1] ^ gmul(gexp[r], g[d]);
      g[0] = gmul(gexp[r], g[0]);
    end
    for (int k = 0; k < 255; k++) w[k] = (k < RS_K) ? 8'(k + 1) : 8'h00;
    for (int k = 0; k < RS_K; k++) begin
      c = w[k];
      for (int j = 1; j <= 16; j++) w[k+j] = w[k+j] ^ gmul(c, g[16-j]);
    end
    for (int k = 0; k < 255; k++) codeword[k] = (k < RS_K) ? 8'(k + 1) : w[k];
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  // Streams frm[start_k..254]; sof goes with symbol 0. Reports any early syn_valid.
  task automatic send_frame(input int start_k, input int gap_pct,
                            output int sv_early, output logic sv_on_last);
    sv_early   = 0;
    sv_on_last = 1'b0;
    for (int k = start_k; k < 255; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        if (syn_valid) sv_early++;
      end
      step(1'b1, (k == 0), frm[k]);
      if (k < 254 && syn_valid) sv_early++;
      if (k == 254) sv_on_last = syn_valid;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (syn_valid !== 1'b0 || syn !== '0 || err_det !== 1'b0 || busy !== 1'b0 || abort_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: sv=%b syn=%h err=%b busy=%b abort=%h required all zero",
               syn_valid, syn, err_det, busy, abort_cnt);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_zero_frame();
    int   early;
    logic last;
    for (int k = 0; k < 255; k++) frm[k] = 8'h00;
    exp_syn = model_syn();
    step(1'b1, 1'b0, 8'h55);  // valid without sof in IDLE is ignored
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_ignore: busy=%b required 0", busy);
    end
    send_frame(0, 0, early, last);
    total++;
    if (early !== 0 || last !== 1'b1) begin
      bad++; $display("FAIL zero_latency: early=%0d sv_on_last=%b required 0 and 1", early, last);
    end
    total++;
    if (syn !== exp_syn || err_det !== 1'b0) begin
      bad++; $display("FAIL zero_syn: syn=%h err=%b required %h 0", syn, err_det, exp_syn);
    end
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (syn_valid !== 1'b0 || busy !== 1'b0 || syn !== exp_syn) begin
      bad++; $display("FAIL zero_pulse_hold: sv=%b busy=%b syn=%h required 0 0 %h", syn_valid, busy, syn, exp_syn);
    end
  endtask

  task automatic test_codeword();
    int   early;
    logic last;
    for (int k = 0; k < 255; k++) frm[k] = codeword[k];
    exp_syn = model_syn();
    send_frame(0, 0, early, last);
    total++;
    if (early !== 0 || last !== 1'b1) begin
      bad++; $display("FAIL cw_latency: early=%0d sv_on_last=%b required 0 and 1", early, last);
    end
    total++;
    if (syn !== exp_syn || syn !== '0 || err_det !== 1'b0) begin
      bad++; $display("FAIL cw_syn: syn=%h err=%b required %h 0", syn, err_det, exp_syn);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_single_error(input int pos, input string name);
    int   early;
    logic last;
    for (int k = 0; k < 255; k++) frm[k] = 8'h00;
    frm[pos] = 8'h01;
    exp_syn = model_syn();
    send_frame(0, 10, early, last);
    total++;
    if (early !== 0 || last !== 1'b1 || syn !== exp_syn || err_det !== 1'b1) begin
      bad++;
      $display("FAIL %s: early=%0d last=%b syn=%h err=%b required 0 1 %h 1",
               name, early, last, syn, err_det, exp_syn);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_degree_one_values();
    total++;
    if (syn[7:0] !== 8'h01 || syn[15:8] !== 8'h02 || syn[23:16] !== 8'h04 ||
        syn[63:56] !== 8'h80 || syn[71:64] !== 8'h1D || syn[127:120] !== 8'h26) begin
      bad++;
      $display("FAIL deg1_consts: S0=%h S1=%h S2=%h S7=%h S8=%h S15=%h required 01 02 04 80 1D 26",
               syn[7:0], syn[15:8], syn[23:16], syn[63:56], syn[71:64], syn[127:120]);
    end
  endtask

  task automatic test_abort_gaps();
    int           early;
    int           pre_early;
    logic         last;
    logic [127:0] prev_syn;
    prev_syn  = syn;
    pre_early = 0;
    for (int k = 0; k < 255; k++) frm[k] = codeword[k];
    for (int k = 0; k < 100; k++) begin
      while ($urandom_range(0, 99) < 30) begin
        step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        if (syn_valid) pre_early++;
      end
      step(1'b1, (k == 0), frm[k]);
      if (syn_valid) pre_early++;
    end
    step(1'b1, 1'b1, frm[0]);  // sof at cnt=100 aborts and restarts
    total++;
    if (syn_valid !== 1'b0 || pre_early !== 0 || busy !== 1'b1 || syn !== prev_syn) begin
      bad++;
      $display("FAIL abort_hold: sv=%b early=%0d busy=%b syn=%h required 0 0 1 %h",
               syn_valid, pre_early, busy, syn, prev_syn);
    end
    send_frame(1, 30, early, last);
    exp_syn = model_syn();
    total++;
    if (early !== 0 || last !== 1'b1) begin
      bad++; $display("FAIL abort_restart_latency: early=%0d sv_on_last=%b required 0 and 1", early, last);
    end
    total++;
    if (syn !== exp_syn || err_det !== 1'b0) begin
      bad++; $display("FAIL abort_syn: syn=%h err=%b required %h 0", syn, err_det, exp_syn);
    end
    total++;
    if (abort_cnt !== EXP_ABORTS) begin
      bad++; $display("FAIL abort_cnt: got=%0d required=%0d", abort_cnt, EXP_ABORTS);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    int   early;
    logic last;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 255; k++) frm[k] = 8'($urandom);
      exp_syn = model_syn();
      send_frame(0, (f % 2) * 20, early, last);
      total++;
      if (early !== 0 || last !== 1'b1 || syn !== exp_syn || err_det !== (|exp_syn)) begin
        bad++;
        $display("FAIL b2b_frame%0d: early=%0d last=%b syn=%h err=%b required 0 1 %h %b",
                 f, early, last, syn, err_det, exp_syn, |exp_syn);
      end
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    int   early;
    int   sv_seen;
    logic last;
    sv_seen = 0;
    for (int k = 0; k < 255; k++) frm[k] = 8'($urandom);
    for (int k = 0; k < 150; k++) step(1'b1, (k == 0), frm[k]);
    din_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b0;
    #1;
    total++;
    if (syn_valid !== 1'b0 || syn !== '0 || err_det !== 1'b0 || busy !== 1'b0 || abort_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: sv=%b syn=%h err=%b busy=%b abort=%h required all zero",
               syn_valid, syn, err_det, busy, abort_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 8'h00);
      if (syn_valid) sv_seen++;
    end
    total++;
    if (sv_seen !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_no_sv: sv_count=%0d busy=%b required 0 0", sv_seen, busy);
    end
    for (int k = 0; k < 255; k++) frm[k] = 8'h00;
    frm[0] = 8'h01;
    exp_syn = model_syn();
    send_frame(0, 15, early, last);
    total++;
    if (early !== 0 || last !== 1'b1 || syn !== exp_syn || err_det !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_sym0: early=%0d last=%b syn=%h err=%b required 0 1 %h 1",
               early, last, syn, err_det, exp_syn);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst       = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    sof       = 1'b0;
    init_tables();
    build_codeword();
    test_reset();
    test_zero_frame();
    test_codeword();
    test_single_error(254, "last_sym_one");
    test_single_error(253, "deg1_one");
    test_degree_one_values();
    test_abort_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
